// File: rtl/jk_flipflop_using_sr.sv
`default_nettype none
// ============================================================================
// Module      : jk_flipflop_using_sr
// Description : WIDTH-bit register of JK flip-flops, each bit built from an
//               SR flip-flop core fed by JK-to-SR excitation logic
//               (S = J & ~Q, R = K & Q). Adds a clock enable, a saturating
//               toggle-event counter and a sticky SR-conflict status flag.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_flipflop_using_sr #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_sat,
  output logic             sr_conflict
);

  // Width of a per-cycle toggle count (0..WIDTH inclusive).
  localparam int c_TOG_W = $clog2(WIDTH + 1);
  // Sum is wide enough that counter + toggles can never wrap.
  localparam int c_SUM_W = CNT_W + $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_s;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_tog_mask;
  logic [c_TOG_W-1:0] w_toggles_now;
  logic [c_SUM_W-1:0] w_cnt_sum;
  logic               w_cnt_hit_max;
  logic               w_conflict_now;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_cnt_sat;
  logic               r_sr_conflict;

  // JK-to-SR excitation: a set is only requested while the bit is low and a
  // reset only while it is high, so S and R are mutually exclusive.
  assign w_s = {WIDTH{en}} & j & ~w_q;
  assign w_r = {WIDTH{en}} & k &  w_q;

  // One SR flip-flop per bit; S=R=1 holds the bit (flagged separately).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic r_bit;

    // SR core state update with asynchronous active-low reset.
    always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
        r_bit <= 1'b0;
      end else begin
        case ({w_s[gi], w_r[gi]})
          2'b10:   r_bit <= 1'b1;
          2'b01:   r_bit <= 1'b0;
          default: r_bit <= r_bit;
        endcase
      end
    end

    assign w_q[gi] = r_bit;
  end

  // Bits that toggle this cycle: enabled with both J and K high.
  assign w_tog_mask = {WIDTH{en}} & j & k;

  // Population count of the toggling bits.
  always_comb begin
    w_toggles_now = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_toggles_now = w_toggles_now + c_TOG_W'(w_tog_mask[i]);
    end
  end

  assign w_cnt_sum      = c_SUM_W'(r_cnt) + c_SUM_W'(w_toggles_now);
  assign w_cnt_hit_max  = (w_cnt_sum >= c_SUM_W'(c_CNT_MAX));
  assign w_conflict_now = |(w_s & w_r);

  // Saturating toggle counter; clear takes priority over this cycle's toggles.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_cnt_sat <= 1'b0;
    end else if (cnt_clr) begin
      r_cnt     <= '0;
      r_cnt_sat <= 1'b0;
    end else if (w_cnt_hit_max) begin
      r_cnt     <= c_CNT_MAX;
      r_cnt_sat <= 1'b1;
    end else begin
      r_cnt     <= w_cnt_sum[CNT_W-1:0];
    end
  end

  // Sticky SR-conflict flag, cleared only by reset.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_sr_conflict <= 1'b0;
    end else if (w_conflict_now) begin
      r_sr_conflict <= 1'b1;
    end
  end

  assign q           = w_q;
  assign q_bar       = ~w_q;
  assign toggle_cnt  = r_cnt;
  assign cnt_sat     = r_cnt_sat;
  assign sr_conflict = r_sr_conflict;

endmodule
`default_nettype wire

// File: tb/tb_jk_flipflop_using_sr.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_flipflop_using_sr
// Description : Self-checking bench for jk_flipflop_using_sr at WIDTH=4, 1, 8
//               against a JK characteristic-equation reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_flipflop_using_sr;

  logic       clk;
  logic       rst_n;

  logic       en4, clr4;
  logic [3:0] j4, k4, q4, qb4;
  logic [7:0] cnt4;
  logic       sat4, cf4;

  logic       en1, clr1;
  logic [0:0] j1, k1, q1, qb1;
  logic [7:0] cnt1;
  logic       sat1, cf1;

  logic       en8, clr8;
  logic [7:0] j8, k8, q8, qb8;
  logic [7:0] cnt8;
  logic       sat8, cf8;

  int n_checks;
  int n_pass;

  // Reference state per instance.
  int m_q4, m_c4, m_q1, m_c1, m_q8, m_c8;
  bit m_s4, m_s1, m_s8;

  jk_flipflop_using_sr #(.WIDTH(4), .CNT_W(8)) u_dut4 (
    .clock(clk), .rst(rst_n), .en(en4), .j(j4), .k(k4), .cnt_clr(clr4),
    .q(q4), .q_bar(qb4), .toggle_cnt(cnt4), .cnt_sat(sat4), .sr_conflict(cf4)
  );

  jk_flipflop_using_sr #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clock(clk), .rst(rst_n), .en(en1), .j(j1), .k(k1), .cnt_clr(clr1),
    .q(q1), .q_bar(qb1), .toggle_cnt(cnt1), .cnt_sat(sat1), .sr_conflict(cf1)
  );

  jk_flipflop_using_sr #(.WIDTH(8), .CNT_W(8)) u_dut8 (
    .clock(clk), .rst(rst_n), .en(en8), .j(j8), .k(k8), .cnt_clr(clr8),
    .q(q8), .q_bar(qb8), .toggle_cnt(cnt8), .cnt_sat(sat8), .sr_conflict(cf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // JK characteristic equation: Q+ = J&~Q | ~K&Q, applied per bit via masks.
  function automatic int jk_next(int qv, int jv, int kv, bit env, int mask);
    if (!env) return qv;
    return ((jv & ~qv) | (~kv & qv)) & mask;
  endfunction

  function automatic int cnt_next(int cv, int jv, int kv, bit env, bit clr, int mask);
    int s;
    if (clr) return 0;
    s = cv + (env ? $countones(jv & kv & mask) : 0);
    return (s > 255) ? 255 : s;
  endfunction

  task automatic model_reset();
    m_q4 = 0; m_c4 = 0; m_s4 = 0;
    m_q1 = 0; m_c1 = 0; m_s1 = 0;
    m_q8 = 0; m_c8 = 0; m_s8 = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q4"},   32'(q4),   32'(m_q4));
    check({tag, "_qb4"},  32'(qb4),  32'(~m_q4 & 'hF));
    check({tag, "_cnt4"}, 32'(cnt4), 32'(m_c4));
    check({tag, "_sat4"}, 32'(sat4), 32'(m_s4));
    check({tag, "_cf4"},  32'(cf4),  32'd0);
    check({tag, "_q1"},   32'(q1),   32'(m_q1));
    check({tag, "_qb1"},  32'(qb1),  32'(~m_q1 & 'h1));
    check({tag, "_cnt1"}, 32'(cnt1), 32'(m_c1));
    check({tag, "_sat1"}, 32'(sat1), 32'(m_s1));
    check({tag, "_cf1"},  32'(cf1),  32'd0);
    check({tag, "_q8"},   32'(q8),   32'(m_q8));
    check({tag, "_qb8"},  32'(qb8),  32'(~m_q8 & 'hFF));
    check({tag, "_cnt8"}, 32'(cnt8), 32'(m_c8));
    check({tag, "_sat8"}, 32'(sat8), 32'(m_s8));
    check({tag, "_cf8"},  32'(cf8),  32'd0);
  endtask

  // One clock edge: predict from the applied inputs, then compare 1 ns later.
  task automatic cycle(input string tag);
    int nq4, nc4, nq1, nc1, nq8, nc8;
    bit ns4, ns1, ns8;
    if (!rst_n) begin
      nq4 = 0; nc4 = 0; ns4 = 0; nq1 = 0; nc1 = 0; ns1 = 0; nq8 = 0; nc8 = 0; ns8 = 0;
    end else begin
      nq4 = jk_next(m_q4, int'(j4), int'(k4), en4, 'hF);
      nc4 = cnt_next(m_c4, int'(j4), int'(k4), en4, clr4, 'hF);
      ns4 = clr4 ? 1'b0 : (m_s4 | (nc4 == 255));
      nq1 = jk_next(m_q1, int'(j1), int'(k1), en1, 'h1);
      nc1 = cnt_next(m_c1, int'(j1), int'(k1), en1, clr1, 'h1);
      ns1 = clr1 ? 1'b0 : (m_s1 | (nc1 == 255));
      nq8 = jk_next(m_q8, int'(j8), int'(k8), en8, 'hFF);
      nc8 = cnt_next(m_c8, int'(j8), int'(k8), en8, clr8, 'hFF);
      ns8 = clr8 ? 1'b0 : (m_s8 | (nc8 == 255));
    end
    @(posedge clk);
    #1;
    m_q4 = nq4; m_c4 = nc4; m_s4 = ns4;
    m_q1 = nq1; m_c1 = nc1; m_s1 = ns1;
    m_q8 = nq8; m_c8 = nc8; m_s8 = ns8;
    check_all(tag);
  endtask

  task automatic idle_others();
    en1 = 1'b0; j1 = '0; k1 = '0; clr1 = 1'b0;
    en8 = 1'b0; j8 = '0; k8 = '0; clr8 = 1'b0;
  endtask

  task automatic randomize_all();
    en4 = ($urandom_range(0, 3) != 0); j4 = 4'($urandom); k4 = 4'($urandom);
    clr4 = ($urandom_range(0, 31) == 0);
    en1 = ($urandom_range(0, 3) != 0); j1 = 1'($urandom); k1 = 1'($urandom);
    clr1 = ($urandom_range(0, 31) == 0);
    en8 = ($urandom_range(0, 3) != 0); j8 = 8'($urandom); k8 = 8'($urandom);
    clr8 = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    idle_others();

    // 1. Reset held with active inputs, then release and hold.
    rst_n = 1'b0; en4 = 1'b1; j4 = 4'hF; k4 = 4'hF; clr4 = 1'b0;
    #2;
    check_all("rst_async");
    cycle("rst_hold");
    cycle("rst_hold");
    @(negedge clk);
    rst_n = 1'b1; j4 = 4'h0; k4 = 4'h0;
    for (int i = 0; i < 3; i++) cycle("post_rst");
    check("post_rst_q", 32'(q4), 32'h0);

    // 2. Set, reset, hold.
    j4 = 4'b0101; k4 = 4'b0000; cycle("set");
    check("set_q", 32'(q4), 32'h5);
    j4 = 4'b0000; k4 = 4'b0001; cycle("reset");
    check("reset_q", 32'(q4), 32'h4);
    j4 = 4'b0000; k4 = 4'b0000; cycle("hold");
    check("hold_q", 32'(q4), 32'h4);
    check("hold_qb", 32'(qb4), 32'hB);

    // 3. Toggle and count, then disabled hold.
    j4 = 4'h0; k4 = 4'hF; cycle("clr_q");
    j4 = 4'hF; k4 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      cycle("toggle");
      check("toggle_q", 32'(q4), (i % 2 == 0) ? 32'hF : 32'h0);
      check("toggle_cnt", 32'(cnt4), 32'(4 * (i + 1)));
    end
    en4 = 1'b0;
    for (int i = 0; i < 2; i++) cycle("en_off");
    check("en_off_q", 32'(q4), 32'hF);
    check("en_off_cnt", 32'(cnt4), 32'd12);

    // 4. Saturation and clear.
    en4 = 1'b1; clr4 = 1'b1; j4 = 4'h0; k4 = 4'h0; cycle("pre_clr");
    clr4 = 1'b0; j4 = 4'hF; k4 = 4'hF;
    for (int i = 0; i < 63; i++) cycle("fill");
    check("fill_cnt", 32'(cnt4), 32'd252);
    check("fill_sat", 32'(sat4), 32'd0);
    for (int i = 0; i < 2; i++) cycle("sat");
    check("sat_cnt", 32'(cnt4), 32'd255);
    check("sat_flag", 32'(sat4), 32'd1);
    clr4 = 1'b1; cycle("clr");
    check("clr_cnt", 32'(cnt4), 32'd0);
    check("clr_sat", 32'(sat4), 32'd0);
    clr4 = 1'b0;

    // 5. Random run with an asynchronous reset pulse between edges.
    for (int i = 0; i < 15; i++) begin
      randomize_all();
      cycle("rnd15");
      if (i == 7) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst");
        #1 rst_n = 1'b1;
      end
    end

    // 6. Long randomized run across all three widths.
    for (int i = 0; i < 200; i++) begin
      randomize_all();
      cycle("rnd200");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jk_flipflop_using_sr.md
Name: jk_flipflop_using_sr

Overview:
WIDTH-bit register of JK flip-flops. Each bit is built from an SR flip-flop core driven by JK-to-SR excitation logic: S = J & ~Q, R = K & Q. This is the converse of the SR-from-JK conversion block. It adds a clock enable, a saturating toggle-event counter, and a sticky SR-conflict status bit, so the conversion can be exercised and checked in the flip-flop conversion series.

Parameters:
WIDTH, 4, number of JK bits in the register
CNT_W, 8, width of the toggle-event counter

Ports:
clock  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  clock enable; when 0 every bit holds
j  input  WIDTH  per-bit J inputs
k  input  WIDTH  per-bit K inputs
cnt_clr  input  1  synchronous clear of toggle_cnt and cnt_sat
q  output  WIDTH  registered state
q_bar  output  WIDTH  always the bitwise complement of q
toggle_cnt  output  CNT_W  saturating count of bit toggles
cnt_sat  output  1  sticky; set when toggle_cnt reaches its maximum
sr_conflict  output  1  sticky; set if any internal S & R is both 1

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0, immediate, independent of clock): q=0, q_bar=all ones, toggle_cnt=0, cnt_sat=0, sr_conflict=0. Outputs stay there while rst=0. The first update happens on the first rising edge after rst returns high.
- Per-bit excitation, combinational from current q:
  - s[i] = en & j[i] & ~q[i]
  - r[i] = en & k[i] & q[i]
- SR core, per bit, on the rising edge:
  - s=0, r=0: hold
  - s=1, r=0: q=1
  - s=0, r=1: q=0
  - s=1, r=1: hold q and set sr_conflict. This case is unreachable by construction; the bench must never see sr_conflict=1.
- Resulting JK behaviour, per bit, latency 1 cycle:
  - jk=00: hold
  - jk=10: set
  - jk=01: reset
  - jk=11: toggle
  - en=0: hold regardless of j/k
- q_bar is derived from the same register as q and is never equal to q, including during reset.
- Toggle counting:
  - toggles_now = popcount(en & j & k), range 0..WIDTH.
  - Each edge: toggle_cnt = min(toggle_cnt + toggles_now, 2^CNT_W - 1). Compute the sum at CNT_W+log2(WIDTH)+1 bits; no wrap-around.
  - cnt_sat is set on the edge where the saturated value is written. It stays 1 until cnt_clr or reset.
- cnt_clr=1 on an edge: toggle_cnt=0 and cnt_sat=0. Clear wins over a simultaneous increment; that cycle's toggles are discarded. cnt_clr does not affect q or sr_conflict.
- sr_conflict is cleared only by reset.
- Reset asserted mid-operation: all outputs return to their reset values immediately, asynchronously. Pending j/k on that edge are ignored.

Test Plan:
1. Reset and hold: rst=0 for 2 cycles with j=k=4'hF, en=1 -> q=0, q_bar=F, toggle_cnt=0 throughout. Release rst, then j=k=0 for 3 cycles -> q stays 0.
2. Set/reset/hold: en=1, j=4'b0101, k=0 -> q=0101 one edge later. Then j=0, k=4'b0001 -> q=0100. Then j=k=0 -> q=0100, q_bar=1011.
3. Toggle and count: q=0, j=k=4'hF, en=1 for 3 edges -> q=F,0,F and toggle_cnt=4,8,12. Repeat with en=0 for 2 edges -> q and toggle_cnt unchanged.
4. Saturation and clear (CNT_W=8): preload toggle_cnt=252, then j=k=F for 2 edges -> toggle_cnt=255, cnt_sat=1, no wrap. Then cnt_clr=1 with j=k=F -> toggle_cnt=0, cnt_sat=0, q still toggles.
5. Async reset mid-run: random j/k/en for 15 cycles, with rst pulsed low 2 ns between edges -> q=0, q_bar=F, toggle_cnt=0 immediately. A scoreboard JK reference model matches q every cycle and sr_conflict stays 0.
6. Randomized 200 cycles with WIDTH=1 and WIDTH=8 -> q matches the JK reference model, q_bar==~q, toggle_cnt matches a saturating popcount model, sr_conflict=0.
